fifo_flags: RTL and testbench

//  Parametrised synchronous FIFO: successor to the plain fifo, with non-power-of-2 depth,

---
 rtl/fifo_flags_pkg.sv | 17 +
 rtl/fifo_ptr_wrap.sv | 25 ++
 rtl/fifo_flags.sv | 102 ++++++++++
 tb/tb_fifo_flags.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flags_pkg.sv
// Shared sizing helpers and defaults for the fifo_flags FIFO and its pointer sub-module.
package fifo_flags_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NUM   = 256;

  // Bits needed to hold an occupancy of 0..num inclusive.
  function automatic int cnt_bits(input int num);
    return $clog2(num + 1);
  endfunction

  // Bits needed to address num entries; at least one bit.
  function automatic int ptr_bits(input int num);
    return (num < 2) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-NUM pointer: advances on inc and wraps from NUM-1 to 0 for any depth.
module fifo_ptr_wrap
  import fifo_flags_pkg::*;
#(
  parameter int NUM = DEFAULT_NUM
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     inc,
  output logic [ptr_bits(NUM)-1:0] ptr
);

  localparam int            PW   = ptr_bits(NUM);
  localparam logic [PW-1:0] LAST = PW'(NUM - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_flags.sv
// Synchronous show-ahead FIFO with occupancy count and full/almost flags, any depth 2..65535.
// Define FIFO_FLAGS_ERR_EN to enable the sticky overflow/underflow indicators.
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM      = DEFAULT_NUM,
  parameter int AF_LEVEL = NUM - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     write_strobe,
  input  logic                     read_strobe,
  output logic [WIDTH-1:0]         read_data,
  output logic                     data_available,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_bits(NUM)-1:0] count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clear
);

  localparam int CW = cnt_bits(NUM);
  localparam int PW = ptr_bits(NUM);

  logic [WIDTH-1:0] mem [NUM];
  logic [PW-1:0]    write_ptr;
  logic [PW-1:0]    read_ptr;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  assign empty  = (count == '0);
  assign rd_acc = read_strobe & ~empty;
  // A write into a full FIFO is fine when a read frees the slot in the same cycle.
  assign wr_acc = write_strobe & (~full | rd_acc);

  fifo_ptr_wrap #(.NUM(NUM)) u_write_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (wr_acc),
    .ptr     (write_ptr)
  );

  fifo_ptr_wrap #(.NUM(NUM)) u_read_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rd_acc),
    .ptr     (read_ptr)
  );

  // NOTE: storage has no reset; contents are meaningless until written and count gates their use.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[write_ptr] <= write_data;
    end
  end

  assign read_data = mem[read_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign data_available = ~empty;
  assign full           = (count == CW'(NUM));
  assign almost_full    = (count >= CW'(AF_LEVEL));
  assign almost_empty   = (count <= CW'(AE_LEVEL));

`ifdef FIFO_FLAGS_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_strobe & ~wr_acc) overflow  <= 1'b1;
      if (read_strobe & ~rd_acc)  underflow <= 1'b1;
    end
  end
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags (NUM=5, AF_LEVEL=4, AE_LEVEL=1): directed table, reset, random vs queue model.
module tb_fifo_flags;

  localparam int WIDTH = 8;
  localparam int NUM   = 5;
  localparam int AFL   = 4;
  localparam int AEL   = 1;
`ifdef FIFO_FLAGS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] write_data;
  logic             write_strobe;
  logic             read_strobe;
  logic [WIDTH-1:0] read_data;
  logic             data_available;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [2:0]       count;
  logic             overflow;
  logic             underflow;
  logic             err_clear;

  fifo_flags #(.WIDTH(WIDTH), .NUM(NUM), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .read_strobe    (read_strobe),
    .read_data      (read_data),
    .data_available (data_available),
    .full           (full),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow),
    .err_clear      (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: a queue of stored words plus the two sticky bits.
  logic [WIDTH-1:0] model_q[$];
  logic             m_ovf;
  logic             m_unf;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] wd;
    int         cnt;
    logic [7:0] head;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic clr, input logic [7:0] wd);
    bit is_full, is_empty, rd_ok, wr_ok;
    is_full  = (model_q.size() == NUM);
    is_empty = (model_q.size() == 0);
    rd_ok    = rd && !is_empty;
    wr_ok    = wr && (!is_full || rd_ok);
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(wd);
    if (ERR_EN) begin
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (wr && !wr_ok) m_ovf = 1'b1;
        if (rd && !rd_ok) m_unf = 1'b1;
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then sample 1 ns after the edge.
  task automatic cycle(input logic wr, input logic rd, input logic clr, input logic [7:0] wd);
    write_strobe = wr;
    read_strobe  = rd;
    err_clear    = clr;
    write_data   = wd;
    @(posedge clk);
    model_step(wr, rd, clr, wd);
    #1;
  endtask

  task automatic check_flags(input string tag, input int cnt);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".full"}, 32'(full), 32'(cnt == NUM));
    check({tag, ".avail"}, 32'(data_available), 32'(cnt != 0));
    check({tag, ".afull"}, 32'(almost_full), 32'(cnt >= AFL));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= AEL));
  endtask

  task automatic check_model(input string tag);
    check_flags(tag, model_q.size());
    if (model_q.size() != 0) check({tag, ".head"}, 32'(read_data), 32'(model_q[0]));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  function automatic vec_t mk(logic wr, logic rd, logic clr, logic [7:0] wd, int cnt,
                              logic [7:0] head, logic ov, logic un);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd;
    v.cnt = cnt; v.head = head; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    err_clear    = 1'b0;
    write_data   = '0;
    m_ovf        = 1'b0;
    m_unf        = 1'b0;
    do_reset();

    check_flags("reset", 0);
    check("reset.ovf", 32'(overflow), 32'd0);
    check("reset.unf", 32'(underflow), 32'd0);

    // Expected values below are written out by hand; ov/un assume the error feature is on.
    vecs.push_back(mk(1, 0, 0, 8'h11, 1, 8'h11, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h12, 2, 8'h11, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h13, 3, 8'h11, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h14, 4, 8'h11, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h15, 5, 8'h11, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h16, 5, 8'h11, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4, 8'h12, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 3, 8'h13, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 2, 8'h14, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h15, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h21, 1, 8'h21, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h22, 2, 8'h21, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h23, 3, 8'h21, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h24, 4, 8'h21, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h25, 5, 8'h21, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'hAA, 5, 8'h22, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4, 8'h23, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 3, 8'h24, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 2, 8'h25, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'hAA, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h42, 1, 8'h42, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h42, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 1));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].wd);
      check_flags(tag, vecs[i].cnt);
      if (vecs[i].cnt != 0) check({tag, ".head"}, 32'(read_data), 32'(vecs[i].head));
      check({tag, ".ovf"}, 32'(overflow), 32'(ERR_EN & vecs[i].ov));
      check({tag, ".unf"}, 32'(underflow), 32'(ERR_EN & vecs[i].un));
    end

    // Asynchronous reset mid-traffic: flags drop before any clock edge.
    cycle(1, 0, 0, 8'h31);
    cycle(1, 0, 0, 8'h32);
    cycle(1, 0, 0, 8'h33);
    #2;
    reset_n = 1'b0;
    #1;
    check_flags("async_rst", 0);
    check("async_rst.ovf", 32'(overflow), 32'd0);
    check("async_rst.unf", 32'(underflow), 32'd0);
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    err_clear    = 1'b0;
    @(negedge clk);
    model_q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    reset_n = 1'b1;
    cycle(1, 0, 0, 8'h5C);
    check_model("post_rst");

    // Random traffic in phases biased toward filling, draining and mixing.
    for (int i = 0; i < 240; i++) begin
      int phase;
      logic wr, rd, clr;
      phase = (i / 20) % 3;
      case (phase)
        0:       begin wr = ($urandom_range(0, 9) < 8); rd = ($urandom_range(0, 9) < 2); end
        1:       begin wr = ($urandom_range(0, 9) < 2); rd = ($urandom_range(0, 9) < 8); end
        default: begin wr = $urandom_range(0, 1) == 1; rd = $urandom_range(0, 1) == 1; end
      endcase
      clr = ($urandom_range(0, 15) == 0);
      cycle(wr, rd, clr, 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
